insertion_sort_engine: RTL and testbench

Self-contained insertion-sort engine that sorts an array of words in place in external memory through AXI4-Lite-style read (AR/R) and write (AW/W/B) channels. It is the parametrised successor to the fixed-width sort controller, with the following additions:
- integrated datapath;
- runtime base address and length;
- ascending/descending order;
- signed/unsigned compare;
- full write-channel handshaking, with no separate write submodule;
- error-code capture.

It sits between the user start/done interface and the memory slave.

---
 rtl/insertion_sort_engine.sv | 210 +++++++++++++++++++++
 tb/tb_insertion_sort_engine.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/insertion_sort_engine.sv
`default_nettype none
// ============================================================================
// Module   : insertion_sort_engine
// Purpose  : In-place insertion sort of a word array held in external memory,
//            accessed through AXI4-Lite-style AR/R and AW/W/B channels.
// Revision : 1.0
// ============================================================================
module insertion_sort_engine #(
  parameter int ADDR_WDTH = 8,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 2,
  parameter int LEN_WDTH  = ADDR_WDTH + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_WDTH-1:0] base_addr,
  input  logic [LEN_WDTH-1:0]  len,
  input  logic                 mode_desc,
  input  logic                 mode_signed,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [RESP_WDTH-1:0] err_resp,
  output logic                 ar_valid,
  input  logic                 ar_ready,
  output logic [ADDR_WDTH-1:0] ar_addr,
  input  logic                 r_valid,
  output logic                 r_ready,
  input  logic [DATA_WDTH-1:0] r_data,
  input  logic [RESP_WDTH-1:0] r_resp,
  output logic                 aw_valid,
  input  logic                 aw_ready,
  output logic [ADDR_WDTH-1:0] aw_addr,
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic [DATA_WDTH-1:0] w_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [RESP_WDTH-1:0] b_resp
);

  localparam logic [3:0] c_idle    = 4'd0;
  localparam logic [3:0] c_key_ar  = 4'd1;
  localparam logic [3:0] c_key_r   = 4'd2;
  localparam logic [3:0] c_chk_j   = 4'd3;
  localparam logic [3:0] c_cmp_ar  = 4'd4;
  localparam logic [3:0] c_cmp_r   = 4'd5;
  localparam logic [3:0] c_decide  = 4'd6;
  localparam logic [3:0] c_shift_w = 4'd7;
  localparam logic [3:0] c_shift_b = 4'd8;
  localparam logic [3:0] c_place_w = 4'd9;
  localparam logic [3:0] c_place_b = 4'd10;
  localparam logic [3:0] c_next_i  = 4'd11;
  localparam logic [3:0] c_done    = 4'd12;
  localparam logic [3:0] c_err     = 4'd13;

  localparam logic signed [LEN_WDTH:0] c_j_one   = 1;
  localparam logic        [LEN_WDTH-1:0] c_len_one = 1;
  localparam logic        [RESP_WDTH-1:0] c_okay  = '0;

  logic [3:0]                r_state;
  logic [ADDR_WDTH-1:0]      r_base;
  logic [LEN_WDTH-1:0]       r_len;
  logic [LEN_WDTH-1:0]       r_i;
  logic signed [LEN_WDTH:0]  r_j;
  logic                      r_desc;
  logic                      r_sgn;
  logic [DATA_WDTH-1:0]      r_key;
  logic [DATA_WDTH-1:0]      r_cmp;
  logic                      r_aw_done;
  logic                      r_w_done;
  logic [RESP_WDTH-1:0]      r_err_resp;

  logic signed [LEN_WDTH:0]  w_i_ext;
  logic signed [LEN_WDTH:0]  w_j_plus1;
  logic [LEN_WDTH-1:0]       w_i_inc;
  logic                      w_skip;
  logic                      w_gt;
  logic                      w_lt;
  logic                      w_move;
  logic                      w_wr_state;
  logic                      w_aw_fin;
  logic                      w_w_fin;
  logic                      w_wr_fin;
  logic                      w_idle_like;

  assign w_i_ext   = $signed({1'b0, r_i});
  assign w_j_plus1 = r_j + c_j_one;
  assign w_i_inc   = r_i + c_len_one;
  assign w_skip    = (w_j_plus1 == w_i_ext);

  // Equal elements never satisfy either strict compare, which keeps the sort stable.
  assign w_gt   = r_sgn ? ($signed(r_cmp) > $signed(r_key)) : (r_cmp > r_key);
  assign w_lt   = r_sgn ? ($signed(r_cmp) < $signed(r_key)) : (r_cmp < r_key);
  assign w_move = r_desc ? w_lt : w_gt;

  assign w_idle_like = (r_state == c_idle) || (r_state == c_done) || (r_state == c_err);
  assign busy     = !w_idle_like;
  assign done     = (r_state == c_done);
  assign error    = (r_state == c_err);
  assign err_resp = r_err_resp;

  assign ar_valid = (r_state == c_key_ar) || (r_state == c_cmp_ar);
  assign ar_addr  = (r_state == c_key_ar) ? r_base + ADDR_WDTH'(r_i) :
                    (r_state == c_cmp_ar) ? r_base + ADDR_WDTH'(r_j) : '0;
  assign r_ready  = (r_state == c_key_r) || (r_state == c_cmp_r);

  assign w_wr_state = (r_state == c_shift_w) || ((r_state == c_place_w) && !w_skip);
  assign aw_valid   = w_wr_state && !r_aw_done;
  assign w_valid    = w_wr_state && !r_w_done;
  assign aw_addr    = w_wr_state ? r_base + ADDR_WDTH'(w_j_plus1) : '0;
  assign w_data     = (r_state == c_shift_w) ? r_cmp : (w_wr_state ? r_key : '0);
  assign b_ready    = (r_state == c_shift_b) || (r_state == c_place_b);

  // AW and W complete independently; the write phase ends once both have.
  assign w_aw_fin = r_aw_done || (aw_valid && aw_ready);
  assign w_w_fin  = r_w_done  || (w_valid && w_ready);
  assign w_wr_fin = w_aw_fin && w_w_fin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_idle;
      r_base     <= '0;
      r_len      <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_desc     <= 1'b0;
      r_sgn      <= 1'b0;
      r_key      <= '0;
      r_cmp      <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_err_resp <= '0;
    end else begin
      case (r_state)
        c_idle, c_done, c_err: begin
          if (start) begin
            r_base     <= base_addr;
            r_len      <= len;
            r_desc     <= mode_desc;
            r_sgn      <= mode_signed;
            r_err_resp <= '0;
            r_i        <= c_len_one;
            r_state    <= (len <= c_len_one) ? c_done : c_key_ar;
          end
        end
        c_key_ar: if (ar_ready) r_state <= c_key_r;
        c_key_r: begin
          if (r_valid) begin
            if (r_resp != c_okay) begin
              r_err_resp <= r_resp;
              r_state    <= c_err;
            end else begin
              r_key   <= r_data;
              r_j     <= w_i_ext - c_j_one;
              r_state <= c_chk_j;
            end
          end
        end
        c_chk_j:  r_state <= r_j[LEN_WDTH] ? c_place_w : c_cmp_ar;
        c_cmp_ar: if (ar_ready) r_state <= c_cmp_r;
        c_cmp_r: begin
          if (r_valid) begin
            if (r_resp != c_okay) begin
              r_err_resp <= r_resp;
              r_state    <= c_err;
            end else begin
              r_cmp   <= r_data;
              r_state <= c_decide;
            end
          end
        end
        c_decide: r_state <= w_move ? c_shift_w : c_place_w;
        c_shift_w, c_place_w: begin
          if ((r_state == c_place_w) && w_skip) begin
            r_state <= c_next_i;
          end else if (w_wr_fin) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= (r_state == c_shift_w) ? c_shift_b : c_place_b;
          end else begin
            r_aw_done <= w_aw_fin;
            r_w_done  <= w_w_fin;
          end
        end
        c_shift_b, c_place_b: begin
          if (b_valid) begin
            if (b_resp != c_okay) begin
              r_err_resp <= b_resp;
              r_state    <= c_err;
            end else if (r_state == c_shift_b) begin
              r_j     <= r_j - c_j_one;
              r_state <= c_chk_j;
            end else begin
              r_state <= c_next_i;
            end
          end
        end
        c_next_i: begin
          r_i     <= w_i_inc;
          r_state <= (w_i_inc == r_len) ? c_done : c_key_ar;
        end
        default: r_state <= c_idle;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_insertion_sort_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_insertion_sort_engine
// Purpose  : Randomised memory slave plus reference-model scoreboard for
//            insertion_sort_engine.
// Revision : 1.0
// ============================================================================
module tb_insertion_sort_engine;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int RW = 2;
  localparam int LW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] len;
  logic          mode_desc, mode_signed;
  logic          busy, done, error;
  logic [RW-1:0] err_resp;
  logic          ar_valid, ar_ready, r_valid, r_ready;
  logic [AW-1:0] ar_addr;
  logic [DW-1:0] r_data;
  logic [RW-1:0] r_resp;
  logic          aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic [AW-1:0] aw_addr;
  logic [DW-1:0] w_data;
  logic [RW-1:0] b_resp;

  always #5 clk = ~clk;

  insertion_sort_engine #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW), .LEN_WDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .mode_desc(mode_desc), .mode_signed(mode_signed), .busy(busy), .done(done),
    .error(error), .err_resp(err_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
  );

  typedef struct {
    int         rd;
    int         wr;
    logic [1:0] err;
    bit         is_err;
  } exp_t;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  exp_t        exp_q[$];
  logic [31:0] exp_mem_q[$];
  exp_t        m_e;
  int          checks = 0;
  int          errors = 0;
  int          jobs_checked = 0;
  bit          stall_en = 1'b0;
  int          rd_cnt = 0, wr_cnt = 0, err_rd = 0, err_wr = 0;
  logic [1:0]  err_code = 2'd0;
  logic [7:0]  rd_a, wr_a;
  logic [31:0] wr_d;
  logic [31:0] dq[$];

  function automatic int stall();
    return stall_en ? int'($urandom_range(0, 5)) : 0;
  endfunction

  function automatic logic [7:0] ea(input logic [7:0] b, input int idx);
    return b + idx[7:0];
  endfunction

  function automatic bit mv(input logic [31:0] c, input logic [31:0] k, input bit desc, input bit sgn);
    if (sgn) return desc ? ($signed(c) < $signed(k)) : ($signed(c) > $signed(k));
    return desc ? (c < k) : (c > k);
  endfunction

  // Textbook insertion sort over ref_mem, tracking how many reads/writes reach the bus.
  task automatic model(input logic [7:0] b, input int n, input bit desc, input bit sgn, output exp_t e);
    logic [31:0] key, c;
    int j;
    e.rd = 0; e.wr = 0; e.err = 2'd0; e.is_err = 1'b0;
    for (int i = 1; i < n; i++) begin
      e.rd++;
      if (e.rd == err_rd) begin e.is_err = 1'b1; e.err = err_code; return; end
      key = ref_mem[ea(b, i)];
      j = i - 1;
      while (j >= 0) begin
        e.rd++;
        if (e.rd == err_rd) begin e.is_err = 1'b1; e.err = err_code; return; end
        c = ref_mem[ea(b, j)];
        if (!mv(c, key, desc, sgn)) break;
        ref_mem[ea(b, j + 1)] = c;
        e.wr++;
        if (e.wr == err_wr) begin e.is_err = 1'b1; e.err = err_code; return; end
        j--;
      end
      if (j + 1 != i) begin
        ref_mem[ea(b, j + 1)] = key;
        e.wr++;
        if (e.wr == err_wr) begin e.is_err = 1'b1; e.err = err_code; return; end
      end
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic set_data(input logic [7:0] b, input logic [31:0] v[$]);
    foreach (v[k]) mem[ea(b, k)] = v[k];
  endtask

  task automatic run_job(input logic [7:0] b, input int n, input bit desc, input bit sgn);
    exp_t e;
    int   target, waited;
    for (int k = 0; k < 256; k++) ref_mem[k] = mem[k];
    model(b, n, desc, sgn, e);
    exp_q.push_back(e);
    for (int k = 0; k < 256; k++) exp_mem_q.push_back(ref_mem[k]);
    rd_cnt = 0;
    wr_cnt = 0;
    target = jobs_checked + 1;
    @(negedge clk);
    start = 1'b1; base_addr = b; len = n[8:0]; mode_desc = desc; mode_signed = sgn;
    @(negedge clk);
    start = 1'b0;
    base_addr = 8'($urandom); len = 9'($urandom); mode_desc = 1'($urandom); mode_signed = 1'($urandom);
    checks++;
    if (n <= 1 ? (done !== 1'b1) : (busy !== 1'b1)) begin
      errors++;
      $display("FAIL start_resp: len=%0d busy=%b done=%b, required %s", n, busy, done, n <= 1 ? "done=1" : "busy=1");
    end
    waited = 0;
    while (jobs_checked < target && waited < 30000) begin
      @(negedge clk);
      waited++;
    end
    if (jobs_checked < target) begin
      errors++;
      $display("FAIL job_timeout: job %0d not retired after %0d cycles, required retirement", target, waited);
      finish_sim();
    end
  endtask

  // Read slave: AR accept after a random stall, then R after another.
  initial begin
    ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = '0;
    forever begin
      @(negedge clk);
      if (ar_valid && rst_n) begin
        repeat (stall()) @(negedge clk);
        ar_ready = 1'b1; rd_a = ar_addr; rd_cnt++;
        @(negedge clk);
        ar_ready = 1'b0;
        repeat (stall()) @(negedge clk);
        r_valid = 1'b1; r_data = mem[rd_a];
        r_resp = (rd_cnt == err_rd) ? err_code : 2'd0;
        @(negedge clk);
        r_valid = 1'b0; r_data = '0; r_resp = '0;
      end
    end
  end

  // Write slave: AW and W readies stalled independently, so either may come first.
  initial begin
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = '0;
    forever begin
      @(negedge clk);
      if (aw_valid && w_valid && rst_n) begin
        fork
          begin
            repeat (stall()) @(negedge clk);
            aw_ready = 1'b1; wr_a = aw_addr;
            @(negedge clk);
            aw_ready = 1'b0;
          end
          begin
            repeat (stall()) @(negedge clk);
            w_ready = 1'b1; wr_d = w_data;
            @(negedge clk);
            w_ready = 1'b0;
          end
        join
        mem[wr_a] = wr_d;
        wr_cnt++;
        repeat (stall()) @(negedge clk);
        b_valid = 1'b1;
        b_resp = (wr_cnt == err_wr) ? err_code : 2'd0;
        @(negedge clk);
        b_valid = 1'b0; b_resp = '0;
      end
    end
  end

  // Stalled valids must stay asserted with unchanged address/data.
  logic        p_arv = 0, p_arr = 0, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0;
  logic [7:0]  p_ara = 0, p_awa = 0;
  logic [31:0] p_wd = 0;
  initial begin
    forever begin
      @(negedge clk); #1;
      if (p_arv && !p_arr) begin
        checks++;
        if (!ar_valid || ar_addr != p_ara) begin
          errors++;
          $display("FAIL ar_hold: ar_valid=%b ar_addr=%h, required 1/%h", ar_valid, ar_addr, p_ara);
        end
      end
      if (p_awv && !p_awr) begin
        checks++;
        if (!aw_valid || aw_addr != p_awa) begin
          errors++;
          $display("FAIL aw_hold: aw_valid=%b aw_addr=%h, required 1/%h", aw_valid, aw_addr, p_awa);
        end
      end
      if (p_wv && !p_wr) begin
        checks++;
        if (!w_valid || w_data != p_wd) begin
          errors++;
          $display("FAIL w_hold: w_valid=%b w_data=%h, required 1/%h", w_valid, w_data, p_wd);
        end
      end
      p_arv = ar_valid; p_arr = ar_ready; p_ara = ar_addr;
      p_awv = aw_valid; p_awr = aw_ready; p_awa = aw_addr;
      p_wv  = w_valid;  p_wr  = w_ready;  p_wd  = w_data;
    end
  end

  // Scoreboard monitor: retires one expectation per accepted start.
  int mcyc, mism, first_bad;
  logic [31:0] ev;
  initial begin
    forever begin
      @(negedge clk); #2;
      if (start) begin
        @(negedge clk); #2;
        mcyc = 0;
        while (!(done || error) && mcyc < 20000) begin
          @(negedge clk); #2;
          mcyc++;
        end
        repeat (3) @(negedge clk);
        #2;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard: DUT finished a job with 0 expectations queued, required 1");
        end else begin
          m_e = exp_q.pop_front();
          checks++;
          if (m_e.is_err ? (error !== 1'b1 || done !== 1'b0) : (done !== 1'b1 || error !== 1'b0)) begin
            errors++;
            $display("FAIL status: done=%b error=%b, required done=%b error=%b", done, error, !m_e.is_err, m_e.is_err);
          end
          checks++;
          if (err_resp !== m_e.err) begin
            errors++;
            $display("FAIL err_resp: got %0d, required %0d", err_resp, m_e.err);
          end
          checks++;
          if (rd_cnt != m_e.rd) begin
            errors++;
            $display("FAIL read_count: got %0d, required %0d", rd_cnt, m_e.rd);
          end
          checks++;
          if (wr_cnt != m_e.wr) begin
            errors++;
            $display("FAIL write_count: got %0d, required %0d", wr_cnt, m_e.wr);
          end
          mism = 0; first_bad = -1;
          for (int k = 0; k < 256; k++) begin
            ev = exp_mem_q.pop_front();
            if (mem[k] !== ev) begin
              if (first_bad < 0) first_bad = k;
              mism++;
            end
          end
          checks++;
          if (mism != 0) begin
            errors++;
            $display("FAIL memory: %0d words differ, first at %h got %h required %h",
                     mism, first_bad[7:0], mem[first_bad], ref_mem[first_bad]);
          end
        end
        jobs_checked++;
      end
    end
  end

  initial begin
    logic [7:0] b;
    int         n;
    start = 1'b0; base_addr = '0; len = '0; mode_desc = 1'b0; mode_signed = 1'b0;
    for (int k = 0; k < 256; k++) mem[k] = $urandom;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, error, err_resp, ar_valid, ar_addr, r_ready, aw_valid, aw_addr,
         w_valid, w_data, b_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b error=%b ar_valid=%b aw_valid=%b w_valid=%b, required all 0",
               busy, done, error, ar_valid, aw_valid, w_valid);
    end
    rst_n = 1'b1;

    dq = '{32'd3, 32'd1, 32'd2, 32'd0};               set_data(8'h10, dq); run_job(8'h10, 4, 0, 0);
    dq = '{32'hFFFF_FFFB, 32'd7, 32'd0};              set_data(8'h20, dq); run_job(8'h20, 3, 1, 1);
    dq = '{32'hFFFF_FFFB, 32'd7, 32'd0};              set_data(8'h20, dq); run_job(8'h20, 3, 0, 0);
    dq = '{32'd1, 32'd2, 32'd3, 32'd4};               set_data(8'h30, dq); run_job(8'h30, 4, 0, 0);
    dq = '{32'd2, 32'd1, 32'd2};                      set_data(8'h40, dq); run_job(8'h40, 3, 0, 0);
    run_job(8'h50, 0, 0, 0);
    run_job(8'h50, 1, 1, 0);
    dq = '{32'd4, 32'd3, 32'd2, 32'd1};               set_data(8'h60, dq);
    err_rd = 3; err_code = 2'd2;                       run_job(8'h60, 4, 0, 0);
    err_rd = 0;
    dq = '{32'd9, 32'd5};                             set_data(8'h70, dq); run_job(8'h70, 2, 0, 0);
    dq = '{32'd5, 32'd6, 32'd1, 32'd2};               set_data(8'hFE, dq); run_job(8'hFE, 4, 0, 0);
    dq = '{32'd8, 32'd7, 32'd6, 32'd5};               set_data(8'h80, dq);
    err_wr = 2; err_code = 2'd3;                       run_job(8'h80, 4, 0, 0);
    err_wr = 0;

    stall_en = 1'b1;
    dq = '{32'd3, 32'd1, 32'd2, 32'd0};               set_data(8'h10, dq); run_job(8'h10, 4, 0, 0);
    for (int t = 0; t < 16; t++) begin
      b = 8'($urandom);
      n = $urandom_range(0, 10);
      for (int k = 0; k < n; k++)
        mem[ea(b, k)] = (t % 2 == 0) ? 32'($urandom_range(0, 7)) - 32'd3 : $urandom;
      if ($urandom_range(0, 3) == 0) begin
        err_code = 2'($urandom_range(1, 3));
        if ($urandom_range(0, 1) == 0) err_rd = $urandom_range(1, 20);
        else                           err_wr = $urandom_range(1, 10);
      end
      run_job(b, n, 1'($urandom), 1'($urandom));
      err_rd = 0;
      err_wr = 0;
    end
    finish_sim();
  end

endmodule
`default_nettype wire
